// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C serial-EEPROM slave: FSM state codes and bus constants.
package i2c_pkg;

    localparam int unsigned STATE_W   = 4;
    localparam int unsigned BIT_CNT_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE      = 4'd0;
    localparam logic [STATE_W-1:0] ST_DEV_ADDR  = 4'd1;
    localparam logic [STATE_W-1:0] ST_DEV_ACK   = 4'd2;
    localparam logic [STATE_W-1:0] ST_WADDR     = 4'd3;
    localparam logic [STATE_W-1:0] ST_ADDR_ACK  = 4'd4;
    localparam logic [STATE_W-1:0] ST_WR_DATA   = 4'd5;
    localparam logic [STATE_W-1:0] ST_WR_ACK    = 4'd6;
    localparam logic [STATE_W-1:0] ST_RD_DATA   = 4'd7;
    localparam logic [STATE_W-1:0] ST_RD_ACK    = 4'd8;
    localparam logic [STATE_W-1:0] ST_IDLE_WAIT = 4'd9;

    localparam logic       I2C_ACK         = 1'b0;
    localparam logic       I2C_NACK        = 1'b1;
    localparam logic [3:0] EEPROM_DEV_TYPE = 4'b1010;

endpackage

// File: rtl/i2c_eeprom_slave_sync.sv
// Bus oversampling: synchronisers on SCL/SDA plus one edge-detect register,
// producing single-clk SCL edge and START/STOP pulses.
module i2c_bus_sync_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s_o,
    output logic scl_rise_c_o,
    output logic scl_fall_c_o,
    output logic start_c_o,
    output logic stop_c_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Reset to the idle-bus level so no spurious edge is seen after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s        = scl_sync_q[SYNC_STAGES-1];
    assign sda_s        = sda_sync_q[SYNC_STAGES-1];
    assign sda_s_o      = sda_s;
    assign scl_rise_c_o = scl_s & ~scl_prev_q;
    assign scl_fall_c_o = ~scl_s & scl_prev_q;
    assign start_c_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_c_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// 24xx-family serial-EEPROM slave with internal memory, oversampling the open-drain
// I2C bus on the system clock. Supports 1/2-byte word address, page writes and write protect.
module i2c_eeprom_slave
    import i2c_pkg::*;
#(
    parameter logic [3:0]  DEV_TYPE    = EEPROM_DEV_TYPE,
    parameter int unsigned ADDR_BYTES  = 1,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned PAGE_SIZE   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [2:0] a_pins,
    input  logic       wp,
    output logic       busy,
    output logic       wr_pulse
);

    localparam int unsigned   AW        = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);
    localparam logic          ADDR_LAST = 1'(ADDR_BYTES - 1);

    logic                 sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;
    logic [STATE_W-1:0]   state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [6:0]           shift_q, shift_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic                 addr_cnt_q, addr_cnt_d;
    logic                 rw_q, rw_d;
    logic                 sda_oe_q, sda_oe_d;
    logic                 wr_pulse_q, wr_pulse_d;
    logic                 busy_q;
    logic                 mem_we_c;
    logic                 dev_match_c;
    logic [7:0]           byte_in_c;
    logic [7:0]           rd_byte_c;
    logic [7:0]           mem_q [MEM_DEPTH];

    i2c_bus_sync_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .scl_i        (scl_i),
        .sda_i        (sda_i),
        .sda_s_o      (sda_s),
        .scl_rise_c_o (scl_rise_c),
        .scl_fall_c_o (scl_fall_c),
        .start_c_o    (start_c),
        .stop_c_o     (stop_c)
    );

    assign byte_in_c   = {shift_q, sda_s};
    assign dev_match_c = (byte_in_c[7:4] == DEV_TYPE) && (byte_in_c[3:1] == a_pins);
    assign rd_byte_c   = mem_q[ptr_q];

    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[ptr_q] <= byte_in_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            addr_cnt_q <= 1'b0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_pulse_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            addr_cnt_q <= addr_cnt_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            wr_pulse_q <= wr_pulse_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    // In the ACK states sda_oe_q doubles as the phase flag: first SCL fall drives, second releases.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        addr_cnt_d = addr_cnt_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        wr_pulse_d = 1'b0;
        mem_we_c   = 1'b0;
        if (start_c) begin
            state_d   = ST_DEV_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_c) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_DEV_ADDR, ST_WADDR, ST_WR_DATA: begin
                    if (scl_rise_c) begin
                        shift_d   = byte_in_c[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            if (state_q == ST_DEV_ADDR) begin
                                rw_d    = byte_in_c[0];
                                state_d = dev_match_c ? ST_DEV_ACK : ST_IDLE;
                            end else if (state_q == ST_WADDR) begin
                                ptr_d   = AW'({ptr_q, byte_in_c});
                                state_d = ST_ADDR_ACK;
                            end else begin
                                mem_we_c   = ~wp;
                                wr_pulse_d = ~wp;
                                ptr_d      = (ptr_q & ~PAGE_MASK) | ((ptr_q + AW'(1)) & PAGE_MASK);
                                state_d    = ST_WR_ACK;
                            end
                        end
                    end
                end
                ST_DEV_ACK: begin
                    if (scl_fall_c) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = ~I2C_ACK;
                        end else if (rw_q) begin
                            state_d   = ST_RD_DATA;
                            shift_d   = rd_byte_c[6:0];
                            sda_oe_d  = ~rd_byte_c[7];
                            bit_cnt_d = '0;
                        end else begin
                            state_d    = ST_WADDR;
                            sda_oe_d   = 1'b0;
                            addr_cnt_d = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_c) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = ~I2C_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            if (addr_cnt_q == ADDR_LAST) begin
                                state_d = ST_WR_DATA;
                            end else begin
                                addr_cnt_d = 1'b1;
                                state_d    = ST_WADDR;
                            end
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall_c) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = ~I2C_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WR_DATA;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise_c) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_c) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + AW'(1);
                            state_d  = ST_RD_ACK;
                        end else if (bit_cnt_q != 4'd0) begin
                            sda_oe_d = ~shift_q[6];
                            shift_d  = {shift_q[5:0], 1'b0};
                        end
                    end
                end
                ST_RD_ACK: begin
                    // bit_cnt 9 marks "master ACKed, send next byte on the coming fall".
                    if (scl_rise_c) begin
                        if (sda_s == I2C_NACK) state_d = ST_IDLE_WAIT;
                        else                   bit_cnt_d = 4'd9;
                    end else if (scl_fall_c && bit_cnt_q == 4'd9) begin
                        state_d   = ST_RD_DATA;
                        shift_d   = rd_byte_c[6:0];
                        sda_oe_d  = ~rd_byte_c[7];
                        bit_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench: task-based I2C master driving two slaves (1-byte/256B and 2-byte/1KB) on one bus.
module tb_i2c_eeprom_slave;

    localparam int Q = 80;

    logic       clk = 1'b0;
    logic       rst_n, m_scl, m_sda, wp;
    logic [2:0] a_pins1, a_pins2;
    logic       oe1, oe2, busy1, busy2, wrp1, wrp2;
    logic       sda_bus;
    int         checks = 0, errors = 0;
    int         wr_cnt1 = 0, wr_cnt2 = 0, oe1_cnt = 0;

    always #5 clk = ~clk;

    assign sda_bus = m_sda & ~oe1 & ~oe2;

    always @(posedge clk) begin
        if (wrp1) wr_cnt1 <= wr_cnt1 + 1;
        if (wrp2) wr_cnt2 <= wr_cnt2 + 1;
        if (oe1)  oe1_cnt <= oe1_cnt + 1;
    end

    i2c_eeprom_slave #(.ADDR_BYTES(1), .MEM_DEPTH(256), .PAGE_SIZE(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .scl_i(m_scl), .sda_i(sda_bus), .sda_oe(oe1),
        .a_pins(a_pins1), .wp(wp), .busy(busy1), .wr_pulse(wrp1)
    );

    i2c_eeprom_slave #(.ADDR_BYTES(2), .MEM_DEPTH(1024), .PAGE_SIZE(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .scl_i(m_scl), .sda_i(sda_bus), .sda_oe(oe2),
        .a_pins(a_pins2), .wp(wp), .busy(busy2), .wr_pulse(wrp2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; b = sda_bus; #Q; m_scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    // START, control byte and word address; nak collects any missing ACK.
    task automatic addr_phase(input logic [7:0] ctrl, input logic [15:0] addr, input int nab,
                              output logic nak);
        logic a;
        i2c_start();
        write_byte(ctrl, a);
        nak = a;
        if (nab == 2) begin
            write_byte(addr[15:8], a);
            nak |= a;
        end
        write_byte(addr[7:0], a);
        nak |= a;
    endtask

    task automatic rand_read_start(input logic [7:0] ctrl, input logic [15:0] addr, input int nab,
                                   output logic nak);
        logic a;
        addr_phase(ctrl, addr, nab, nak);
        i2c_start();
        write_byte(ctrl | 8'h01, a);
        nak |= a;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack, nak, b;
        logic [7:0] d;
        int         w0, o0;

        rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1; wp = 1'b0;
        a_pins1 = 3'b000; a_pins2 = 3'b100;
        repeat (5) @(posedge clk);
        #1;
        check("rst_sda_oe", {oe2, oe1}, 2'b00);
        check("rst_busy", {busy2, busy1}, 2'b00);
        check("rst_wr_pulse", {wrp2, wrp1}, 2'b00);
        rst_n = 1'b1;
        #Q;

        // Byte write 0x5A @0x10
        i2c_start();
        write_byte(8'hA0, ack); check("bw_ctrl_ack", ack, 1'b0);
        check("bw_busy", busy1, 1'b1);
        write_byte(8'h10, ack); check("bw_addr_ack", ack, 1'b0);
        w0 = wr_cnt1;
        write_byte(8'h5A, ack); check("bw_data_ack", ack, 1'b0);
        i2c_stop();
        #Q;
        check("bw_wr_pulses", 32'(wr_cnt1 - w0), 32'd1);
        check("bw_busy_after_stop", busy1, 1'b0);

        // Random read @0x10
        rand_read_start(8'hA0, 16'h0010, 1, nak); check("rr_acks", nak, 1'b0);
        read_byte(d, 1'b1); i2c_stop();
        check("rr_data", d, 8'h5A);

        // Wrong device address
        o0 = oe1_cnt;
        i2c_start();
        write_byte(8'hA2, ack); check("wa_nack", ack, 1'b1);
        check("wa_oe_never", 32'(oe1_cnt - o0), 32'd0);
        check("wa_busy", {busy2, busy1}, 2'b00);
        i2c_stop();

        // Write protect: seed 0x77 @0x20, then protected write of 0x33
        addr_phase(8'hA0, 16'h0020, 1, nak);
        write_byte(8'h77, ack); i2c_stop();
        check("wp_seed_ack", {nak, ack}, 2'b00);
        wp = 1'b1;
        w0 = wr_cnt1;
        addr_phase(8'hA0, 16'h0020, 1, nak);
        write_byte(8'h33, ack); i2c_stop();
        #Q;
        check("wp_acks", {nak, ack}, 2'b00);
        check("wp_no_pulse", 32'(wr_cnt1 - w0), 32'd0);
        wp = 1'b0;
        rand_read_start(8'hA0, 16'h0020, 1, nak);
        read_byte(d, 1'b1); i2c_stop();
        check("wp_readback", d, 8'h77);

        // Page wrap: 10 bytes 0..9 from @0x06
        w0 = wr_cnt1;
        addr_phase(8'hA0, 16'h0006, 1, nak);
        for (int i = 0; i < 10; i++) begin
            write_byte(8'(i), ack);
            nak |= ack;
        end
        i2c_stop();
        #Q;
        check("pw_acks", nak, 1'b0);
        check("pw_wr_pulses", 32'(wr_cnt1 - w0), 32'd10);
        rand_read_start(8'hA0, 16'h0000, 1, nak); check("pw_rd_acks", nak, 1'b0);
        for (int i = 0; i < 8; i++) begin
            read_byte(d, (i == 7));
            check($sformatf("pw_mem%0d", i), d, 32'(i + 2));
        end
        i2c_stop();

        // Sequential-read wrap from @0xFF
        addr_phase(8'hA0, 16'h00FF, 1, nak);
        write_byte(8'hEE, ack); i2c_stop();
        rand_read_start(8'hA0, 16'h00FF, 1, nak); check("sr_acks", {nak, ack}, 2'b00);
        read_byte(d, 1'b0); check("sr_ff", d, 8'hEE);
        read_byte(d, 1'b0); check("sr_00", d, 8'h02);
        read_byte(d, 1'b1); check("sr_01", d, 8'h03);
        i2c_stop();

        // Current-address read continues at 0x02
        i2c_start();
        write_byte(8'hA1, ack); check("ca_ack", ack, 1'b0);
        read_byte(d, 1'b1); i2c_stop();
        check("ca_data", d, 8'h04);

        // 2-byte address device: write 0xC3 @0x0123, read back
        addr_phase(8'hA8, 16'h0123, 2, nak);
        write_byte(8'hC3, ack); i2c_stop();
        check("w2_acks", {nak, ack}, 2'b00);
        rand_read_start(8'hA8, 16'h0123, 2, nak); check("r2_acks", nak, 1'b0);
        read_byte(d, 1'b1); i2c_stop();
        check("r2_data", d, 8'hC3);

        // Abort with reset while the slave drives bit 5 (0) of 0xC3
        rand_read_start(8'hA8, 16'h0123, 2, nak); check("ab_acks", nak, 1'b0);
        recv_bit(b); check("ab_bit7", b, 1'b1);
        recv_bit(b); check("ab_bit6", b, 1'b1);
        check("ab_oe_driving", oe2, 1'b1);
        rst_n = 1'b0;
        #1;
        check("ab_oe_released", oe2, 1'b0);
        check("ab_busy", busy2, 1'b0);
        m_scl = 1'b1; #Q; m_sda = 1'b1; #Q;
        rst_n = 1'b1;
        #Q;

        // After reset: address bits above AW ignored (0x0523 -> 0x123), dut1 pointer back at 0
        rand_read_start(8'hA8, 16'h0523, 2, nak); check("post_acks", nak, 1'b0);
        read_byte(d, 1'b1); i2c_stop();
        check("post_r2_data", d, 8'hC3);
        i2c_start();
        write_byte(8'hA1, ack); check("post_ca_ack", ack, 1'b0);
        read_byte(d, 1'b1); i2c_stop();
        check("post_ca_data", d, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
